// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, stage k
// moves the operand by 2^k. A single advance signal stalls the whole pipe.

module pbs_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int K       = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_adv,
  input  logic               i_vld,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  output logic               o_vld,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [1:0]         o_mode
);
  localparam int D = 1 << K;

  logic [WIDTH-1:0]   w_shift, w_next;
  logic               r_vld;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [1:0]         r_mode;

  // For SRA the MSB never changes between stages, so it still carries the
  // original sign bit when a later stage needs it as fill.
  always_comb begin
    w_shift = i_data;
    case (i_mode)
      2'b00:   w_shift = i_data << D;
      2'b01:   w_shift = i_data >> D;
      2'b10:   w_shift = {{D{i_data[WIDTH-1]}}, i_data[WIDTH-1:D]};
      default: w_shift = {i_data[D-1:0], i_data[WIDTH-1:D]};
    endcase
    w_next = i_shamt[K] ? w_shift : i_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld   <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_mode  <= '0;
    end else if (i_adv) begin
      r_vld   <= i_vld;
      r_data  <= w_next;
      r_shamt <= i_shamt;
      r_mode  <= i_mode;
    end
  end

  assign o_vld   = r_vld;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_mode  = r_mode;
endmodule

module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [SHAMT_W:0]              w_vld_pipe;
  logic [SHAMT_W:0][WIDTH-1:0]   w_data;
  logic [SHAMT_W:0][SHAMT_W-1:0] w_shamt;
  logic [SHAMT_W:0][1:0]         w_mode;
  logic                          w_advance;
  logic                          w_unused;

  // Only out_ready reaches in_ready combinationally; out_valid is a register.
  assign w_advance = !w_vld_pipe[SHAMT_W] || out_ready;
  assign in_ready  = w_advance && !reset;

  assign w_vld_pipe[0] = in_valid && in_ready;
  assign w_data[0]     = in_data;
  assign w_shamt[0]    = in_shamt;
  assign w_mode[0]     = in_mode;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    pbs_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .K(k)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .i_adv   (w_advance),
      .i_vld   (w_vld_pipe[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_mode  (w_mode[k]),
      .o_vld   (w_vld_pipe[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_mode  (w_mode[k+1])
    );
  end

  assign out_valid = w_vld_pipe[SHAMT_W];
  assign out_data  = w_data[SHAMT_W];
  assign w_unused  = ^{w_shamt[SHAMT_W], w_mode[SHAMT_W]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed checks on a 32-bit shifter plus randomized backpressure runs on
// 8/32/64-bit instances against a width-generic reference shift function.

module tb_pipelined_barrel_shifter;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROTR = 2'b11;
  localparam int NBEATS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit rnd_done [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_sh(input logic [63:0] d, input int sh,
                                         input logic [1:0] m, input int w);
    logic [63:0] mask, x;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (m)
      SLL:     return (x << sh) & mask;
      SRL:     return x >> sh;
      SRA:     return (x >> sh) | (x[w-1] ? (mask & ~(mask >> sh)) : 64'd0);
      default: return ((x >> sh) | (x << (w - sh))) & mask;
    endcase
  endfunction

  // ---------------- directed DUT (WIDTH=32) ----------------
  logic        d_rst, d_iv, d_ir, d_ov, d_ordy;
  logic [31:0] d_id, d_od;
  logic [4:0]  d_ish;
  logic [1:0]  d_im;

  pipelined_barrel_shifter #(.WIDTH(32)) u_dut (
    .clock(clk), .reset(d_rst), .in_data(d_id), .in_shamt(d_ish), .in_mode(d_im),
    .in_valid(d_iv), .in_ready(d_ir), .out_data(d_od), .out_valid(d_ov),
    .out_ready(d_ordy)
  );

  task automatic send1(input string tag, input logic [31:0] data, input logic [4:0] sh,
                       input logic [1:0] m, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    d_iv = 1'b1; d_id = data; d_ish = sh; d_im = m; d_ordy = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(d_ir), 64'd1);
    @(negedge clk);
    d_iv = 1'b0;
    lat = 1;
    while (!d_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_data"}, 64'(d_od), 64'(exp));
  endtask

  // ---------------- random DUTs (WIDTH=8/32/64) ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W  = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
    localparam int SW = $clog2(W);
    logic          rst, iv, ir, ov, ordy;
    logic [W-1:0]  id, od;
    logic [SW-1:0] ish;
    logic [1:0]    im;
    logic [63:0]   q[$];
    int            sent;

    pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
      .clock(clk), .reset(rst), .in_data(id), .in_shamt(ish), .in_mode(im),
      .in_valid(iv), .in_ready(ir), .out_data(od), .out_valid(ov), .out_ready(ordy)
    );

    initial begin
      rst = 1'b1; iv = 1'b0; id = '0; ish = '0; im = '0; ordy = 1'b0; sent = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 40000 && (sent < NBEATS || q.size() != 0); cyc++) begin
        @(negedge clk);
        iv   = (sent < NBEATS) && ($urandom_range(0, 4) != 0);
        id   = W'({$urandom, $urandom});
        ish  = SW'($urandom);
        im   = 2'($urandom);
        ordy = (sent >= NBEATS) || ($urandom_range(0, 3) != 0);
        #1;
        if (iv && ir) begin
          q.push_back(ref_sh(64'(id), int'(ish), im, W));
          sent++;
        end
        if (ov && ordy) begin
          chk($sformatf("rnd%0d_pending", W), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) chk($sformatf("rnd%0d_data", W), 64'(od), q.pop_front());
        end
      end
      chk($sformatf("rnd%0d_sent", W), 64'(sent), 64'(NBEATS));
      chk($sformatf("rnd%0d_leftover", W), 64'(q.size()), 64'd0);
      rnd_done[gi] = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int idx, got, cyc, first, last, seen;
    logic [31:0] held;
    logic [1:0] modes [4];
    modes = '{SLL, SRL, SRA, ROTR};

    d_rst = 1'b1; d_iv = 1'b0; d_id = '0; d_ish = '0; d_im = SLL; d_ordy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ovalid", 64'(d_ov), 64'd0);
    chk("rst_odata", 64'(d_od), 64'd0);
    chk("rst_iready", 64'(d_ir), 64'd0);
    d_rst = 1'b0;
    #1 chk("post_rst_iready", 64'(d_ir), 64'd1);

    send1("sra8",    32'h8000_0000, 5'd8,  SRA,  32'hFF80_0000);
    send1("srl4",    32'hFFFF_FFFF, 5'd4,  SRL,  32'h0FFF_FFFF);
    send1("sll31",   32'h0000_0001, 5'd31, SLL,  32'h8000_0000);
    send1("rotr7",   32'h1234_5678, 5'd7,  ROTR, 32'hF024_68AC);
    send1("sra31",   32'h8000_0000, 5'd31, SRA,  32'hFFFF_FFFF);
    send1("rotr31",  32'h0000_0001, 5'd31, ROTR, 32'h0000_0002);
    send1("srl31",   32'h8000_0000, 5'd31, SRL,  32'h0000_0001);
    foreach (modes[i]) send1($sformatf("sh0_m%0d", i), 32'hA5A5_A5A5, 5'd0, modes[i], 32'hA5A5_A5A5);

    // Backpressure: fill the stalled pipe, then drain.
    @(negedge clk);
    d_ordy = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      d_iv = 1'b1; d_id = 32'h1; d_ish = 5'(idx); d_im = SLL;
      #1 if (d_ir) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd5);
    chk("bp_iready", 64'(d_ir), 64'd0);
    chk("bp_ovalid", 64'(d_ov), 64'd1);
    chk("bp_head", 64'(d_od), 64'h1);
    held = d_od;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_hold_data", 64'(d_od), 64'(held));
      chk("bp_hold_valid", 64'(d_ov), 64'd1);
      chk("bp_hold_iready", 64'(d_ir), 64'd0);
    end
    got = 0; cyc = 0; first = -1; last = -1;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      d_ordy = 1'b1;
      d_iv = (idx < 8);
      d_ish = 5'(idx);
      #1;
      if (d_iv && d_ir) idx++;
      if (d_ov) begin
        chk($sformatf("bp_out%0d", got), 64'(d_od), 64'(32'h1 << got));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      cyc++;
    end
    d_iv = 1'b0;
    chk("bp_drained", 64'(got), 64'd8);
    chk("bp_span", 64'(last - first + 1), 64'd8);
    chk("bp_first", 64'(first), 64'd0);

    // Reset with three beats in flight.
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      d_iv = 1'b1; d_id = 32'h0BAD_0000 | 32'(c); d_ish = 5'd0; d_im = SLL; d_ordy = 1'b1;
      #1 chk($sformatf("mid_acc%0d", c), 64'(d_ir), 64'd1);
    end
    @(negedge clk);
    d_iv = 1'b0; d_rst = 1'b1;
    #1 chk("mid_rst_iready", 64'(d_ir), 64'd0);
    @(negedge clk);
    d_rst = 1'b0;
    #1;
    chk("mid_rst_ovalid", 64'(d_ov), 64'd0);
    chk("mid_rst_odata", 64'(d_od), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_ov) seen++;
    end
    chk("mid_rst_ghosts", 64'(seen), 64'd0);
    send1("post_rst", 32'h0000_00F0, 5'd4, ROTR, 32'h0000_000F);

    for (int c = 0; c < 45000 && !(rnd_done[0] && rnd_done[1] && rnd_done[2]); c++)
      @(negedge clk);
    chk("rnd_finished", 64'(rnd_done[0] && rnd_done[1] && rnd_done[2]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
